// File: rtl/timer_countdown.sv
// BCD countdown timer with per-digit modulus (mod-6 or mod-10), load/start/stop control
// and a one-cycle done pulse on expiry.
module timer_countdown #(
    parameter int                  N_DIGITS  = 4,
    parameter logic [N_DIGITS-1:0] MOD6_MASK = 4'b0010
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  en,
    input  logic                  loadn,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    output logic [4*N_DIGITS-1:0] out,
    output logic                  zero,
    output logic                  done,
    output logic                  running,
    output logic [1:0]            state
);

    localparam int W = 4 * N_DIGITS;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOADED = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_PAUSED = 2'd3;

    logic [W-1:0] cnt_q, cnt_d;
    logic [1:0]   state_q, state_d;
    logic         done_q, done_d;
    logic         expired_q, expired_d;

    logic [W-1:0] load_val;
    logic [W-1:0] dec_val;
    logic         borrow;

    function automatic logic [3:0] digit_mod(input int unsigned i);
        return MOD6_MASK[i] ? 4'd6 : 4'd10;
    endfunction

    always_comb begin
        load_val = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (data[4*i +: 4] >= digit_mod(i))
                load_val[4*i +: 4] = digit_mod(i) - 4'd1;
            else
                load_val[4*i +: 4] = data[4*i +: 4];
        end
    end

    // Borrow ripples upward through digits that are already 0.
    always_comb begin
        dec_val = cnt_q;
        borrow  = 1'b1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (borrow) begin
                if (cnt_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = digit_mod(i) - 4'd1;
                end else begin
                    dec_val[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        state_d   = state_q;
        done_d    = 1'b0;
        expired_d = expired_q;
        if (en) begin
            if (!loadn) begin
                cnt_d     = load_val;
                state_d   = (load_val != '0) ? S_LOADED : S_IDLE;
                expired_d = 1'b0;
            end else if (stop) begin
                expired_d = 1'b0;
                if (state_q == S_RUN) begin
                    state_d = S_PAUSED;
                end else if (state_q == S_PAUSED || state_q == S_LOADED) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end else if (start) begin
                expired_d = 1'b0;
                if (state_q == S_LOADED || state_q == S_PAUSED)
                    state_d = S_RUN;
            end else if (tick && state_q == S_RUN) begin
                cnt_d = dec_val;
                if (dec_val == '0) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    expired_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q     <= '0;
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    assign out     = cnt_q;
    assign zero    = (cnt_q == '0);
    assign done    = done_q;
    assign running = (state_q == S_RUN);
    assign state   = state_q;

endmodule

// File: doc/timer_countdown.md
TIMER_COUNTDOWN -- requirements
Module: timer_countdown

Interface
REQ-001 Parameter N_DIGITS, default 4; number of BCD digits, legal range 2..8; digit 0 is least significant.
REQ-002 Parameter MOD6_MASK, default 4'b0010, width N_DIGITS; bit i = 1 means digit i counts modulo 6, otherwise modulo 10 (default gives MM:SS, max 99:59).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge except reset.
REQ-004 clrn  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  global enable; when low, all synchronous activity is frozen, including load, start, stop and tick.
REQ-006 loadn  input  1  synchronous active-low load strobe.
REQ-007 data  input  4*N_DIGITS  preset value, digit i at bits [4i+3:4i].
REQ-008 start  input  1  one-cycle start request.
REQ-009 stop  input  1  one-cycle pause/cancel request.
REQ-010 tick  input  1  one-cycle time-base strobe; one tick is one count.
REQ-011 out  output  4*N_DIGITS  current count, registered.
REQ-012 zero  output  1  high when all digits of out are 0.
REQ-013 done  output  1  one-cycle pulse on expiry.
REQ-014 running  output  1  high in RUN.
REQ-015 state  output  2  encoding: IDLE=0, LOADED=1, RUN=2, PAUSED=3; EXPIRED is reported as IDLE with zero=1 plus an internal expired flag (see REQ-024).

Function
REQ-016 Priority per enabled cycle: load > stop > start > tick.
REQ-017 Load (loadn=0, en=1): each digit is loaded from data, clamped to modulus-1 when it is greater than or equal to its modulus; state goes to LOADED if the clamped value is nonzero, else IDLE; accepted from any state.
REQ-018 stop in RUN goes to PAUSED with count held; stop in PAUSED or LOADED clears out to 0 and goes to IDLE; stop in IDLE clears the expired flag.
REQ-019 start in LOADED or PAUSED goes to RUN; start in IDLE is ignored.
REQ-020 In RUN, tick decrements the count by one with cascaded borrow: digit 0 always steps, and digit i steps only when all lower digits are 0; a stepping digit at 0 wraps to modulus-1; no other digit changes.
REQ-021 tick outside RUN, or with en=0, has no effect.
REQ-022 A tick in RUN that makes the count 0 moves state to IDLE, drops running and raises done for exactly one cycle; the count stays 0 and never wraps past 0.
REQ-023 out, zero, done, running and state update on the same edge (one-cycle latency from input to output); zero is derived from the registered count.
REQ-024 The internal expired flag sets with done and clears on load, start or stop; done never pulses twice for a single expiry.
REQ-025 A stop and a tick in the same cycle in RUN: the stop wins and no decrement occurs.
REQ-026 A load during RUN stops the count and takes the new value (state LOADED or IDLE per REQ-017).

Reset
REQ-027 clrn=0 immediately, without waiting for a clock edge, forces out=0, state=IDLE, zero=1, done=0, running=0 and expired=0.
REQ-028 Reset held low overrides all inputs; the first active edge after release behaves as IDLE.
REQ-029 Reset asserted mid-RUN discards the count; no done pulse is produced.

Verification
REQ-030 Default parameters: load 16'h0130, start, 1 tick -> out=16'h0129, running=1.
REQ-031 Borrow cascade: count 16'h0100 in RUN, tick -> out=16'h0059; count 16'h1000, tick -> out=16'h0959.
REQ-032 Expiry: load 16'h0001, start, tick -> out=16'h0000, done=1 for 1 cycle, state=IDLE, zero=1; further ticks -> no change, no further done.
REQ-033 Clamp and zero load: load 16'hFFFF -> out=16'h9959, state=LOADED; load 16'h0000 -> state=IDLE, and a following start is ignored.
REQ-034 Pause/cancel: RUN at 16'h0045, stop+tick in the same cycle -> out=16'h0045, state=PAUSED; stop again -> out=0, state=IDLE; en=0 with a tick -> no change.
REQ-035 Async reset: clrn low between clock edges during RUN at 16'h0230 -> out=0, zero=1 before the next edge; no done pulse is produced.
